// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame controller.
package fft_pkg;

    localparam int CFG_FWD_BIT  = 0;
    localparam int FFT_SAMPLE_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_SEND,
        ST_WAIT_OUT,
        ST_GAP,
        ST_HALT
    } fft_state_e;

endpackage

// File: rtl/fft_frame_ctrl.sv
// Sequences config, one sample frame and an idle gap around an AXI-stream FFT core.
// Define FFT_FRAME_CTRL_ERR_STOP_EN to freeze in HALT on any FFT event pulse.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int NFFT_LOG2  = 3,
    parameter int GAP_CYCLES = 100,
    parameter int DATA_W     = FFT_SAMPLE_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              run,
    input  logic              inverse,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [7:0]        fft_cfg_tdata,
    output logic              fft_cfg_tvalid,
    input  logic              fft_cfg_tready,
    output logic [DATA_W-1:0] fft_in_tdata,
    output logic              fft_in_tvalid,
    input  logic              fft_in_tready,
    output logic              fft_in_tlast,
    input  logic              fft_out_tvalid,
    input  logic              fft_out_tready,
    input  logic              fft_out_tlast,
    input  logic              ev_tlast_missing,
    input  logic              ev_tlast_unexpected,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err
);

    localparam int                   GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
    localparam logic [NFFT_LOG2-1:0] SMP_LAST = '1;
    localparam logic [NFFT_LOG2-1:0] SMP_ONE  = NFFT_LOG2'(1);

    fft_state_e           state_q, state_d;
    logic                 dir_q, dir_d;
    logic [NFFT_LOG2-1:0] smp_cnt_q, smp_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 err_q, err_d;

    logic ev_any;
    logic out_last_hs;

    assign ev_any      = ev_tlast_missing | ev_tlast_unexpected;
    assign out_last_hs = fft_out_tvalid & fft_out_tready & fft_out_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            smp_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            smp_cnt_q   <= smp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        smp_cnt_d      = smp_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        err_d          = err_q | ev_any;
        s_tready       = 1'b0;
        fft_in_tvalid  = 1'b0;
        fft_in_tdata   = '0;
        fft_in_tlast   = 1'b0;
        fft_cfg_tvalid = 1'b0;
        fft_cfg_tdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_CONFIG;
                    dir_d   = inverse;
                end
            end
            ST_CONFIG: begin
                fft_cfg_tvalid             = 1'b1;
                fft_cfg_tdata[CFG_FWD_BIT] = ~dir_q;
                if (fft_cfg_tready) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Zero-latency pass-through; the core's ready paces the source directly.
                s_tready      = fft_in_tready;
                fft_in_tvalid = s_tvalid;
                fft_in_tdata  = s_tdata;
                fft_in_tlast  = (smp_cnt_q == SMP_LAST);
                if (s_tvalid && fft_in_tready) begin
                    if (smp_cnt_q == SMP_LAST) begin
                        smp_cnt_d = '0;
                        state_d   = ST_WAIT_OUT;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SMP_ONE;
                    end
                end
            end
            ST_WAIT_OUT: begin
                if (out_last_hs) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // A zero-length gap still spends one cycle here.
                if (gap_cnt_q >= GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (run) begin
                        state_d = ST_CONFIG;
                        dir_d   = inverse;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef FFT_FRAME_CTRL_ERR_STOP_EN
        if (ev_any) begin
            state_d = ST_HALT;
        end
`endif
    end

    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are aclk and aresetn.
REQ-002 The block SHALL provide these parameters:
- NFFT_LOG2, default 3: frame length is 2**NFFT_LOG2 samples.
- GAP_CYCLES, default 100: idle cycles between frames.
- DATA_W, default 64: complex sample width, {imag float32, real float32}.
REQ-003 The block SHALL provide these ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- run  in  1  level; while high, frames repeat.
- inverse  in  1  requested transform direction (1 = IFFT).
- s_tdata/s_tvalid/s_tready  in/in/out  DATA_W/1/1  sample source stream.
- fft_cfg_tdata/fft_cfg_tvalid/fft_cfg_tready  out/out/in  8/1/1  FFT config channel.
- fft_in_tdata/fft_in_tvalid/fft_in_tready/fft_in_tlast  out/out/in/out  DATA_W/1/1/1  FFT data input.
- fft_out_tvalid/fft_out_tready/fft_out_tlast  in/in/in  1/1/1  FFT output monitor.
- ev_tlast_missing/ev_tlast_unexpected  in/in  1/1  FFT event pulses.
- busy  out  1  high in any state except IDLE.
- frame_cnt  out  16  completed output frames.
- err  out  1  sticky framing error.

Function
REQ-010 The FSM SHALL have the states IDLE, CONFIG, SEND, WAIT_OUT and GAP.
REQ-011 IDLE SHALL go to CONFIG when run=1 and latch inverse into dir_q.
REQ-012 CONFIG SHALL drive fft_cfg_tvalid=1 with fft_cfg_tdata={7'b0,~dir_q} (bit0: 1 = forward) and go to SEND on the cycle fft_cfg_tvalid and fft_cfg_tready are both high.
REQ-013 In SEND the data path SHALL be combinational with zero latency:
- fft_in_tdata = s_tdata.
- fft_in_tvalid = s_tvalid.
- s_tready = fft_in_tready.
- Outside SEND, s_tready = 0 and fft_in_tvalid = 0.
REQ-014 The sample counter SHALL increment on each fft_in handshake; fft_in_tlast SHALL be 1 exactly when the count equals 2**NFFT_LOG2-1; on the last handshake the counter SHALL clear and the FSM go to WAIT_OUT.
REQ-015 WAIT_OUT SHALL go to GAP on a cycle where fft_out_tvalid, fft_out_tready and fft_out_tlast are all high, and frame_cnt SHALL increment on that cycle, wrapping 0xFFFF -> 0.
REQ-016 GAP SHALL count GAP_CYCLES cycles, then go to CONFIG if run=1 (re-latching inverse) or to IDLE otherwise; GAP_CYCLES=0 SHALL leave after one cycle.
REQ-017 Deasserting run mid-frame SHALL NOT abort the frame; the block finishes through GAP, then goes to IDLE.
REQ-018 err SHALL set on any cycle where ev_tlast_missing or ev_tlast_unexpected is high, and clears only on reset.
REQ-019 An inverse change outside IDLE and GAP exit SHALL have no effect until the next CONFIG.
REQ-020 An output-frame tlast arriving in the same cycle as an event pulse SHALL both count the frame and set err.

Reset
REQ-030 While aresetn=0, all of the following SHALL hold:
- The state is IDLE and the counters are 0.
- busy, err, fft_cfg_tvalid, fft_in_tvalid, fft_in_tlast and s_tready are 0.
- frame_cnt is 0 and dir_q is 0.
REQ-031 Reset asserted mid-frame SHALL drop all valids asynchronously; the partially sent frame is abandoned.

Configuration
REQ-040 The macro FFT_FRAME_CTRL_ERR_STOP_EN SHALL select error handling:
- Defined: an event pulse in any state moves the FSM to a sixth state, HALT, with all valids low and busy=1; HALT is left only through reset.
- Undefined: errors only set err, and sequencing continues.

Structure
REQ-050 The shared package fft_pkg SHALL hold:
- the state enum;
- the config bit constant CFG_FWD_BIT=0;
- the FFT_SAMPLE_W=64 constant.
REQ-051 The block SHALL be a single module with no sub-modules; the gap and sample counters are inline.

Verification
REQ-060 The bench SHALL cover these directed scenarios:
- run=1, inverse=0, cfg_tready=1, 8 samples 0x3f800000..., fft_in_tready=1: exactly one cfg handshake with tdata=0x01, then 8 data beats with tlast on beat 8 only.
- fft_in_tready toggled 1/0 each cycle: 8 beats in 16 cycles, with no beat duplicated or dropped.
- Output tlast returned after 20 cycles: frame_cnt=1, then 100 GAP cycles, then a second cfg handshake.
- inverse=1 latched, then inverse=0 mid-SEND: cfg tdata=0x00 for that frame and 0x01 for the next.
- run dropped during SEND: the frame completes, busy falls after GAP, and there is no further cfg handshake.
- ev_tlast_unexpected pulsed: err=1; with ERR_STOP_EN the block sits in HALT until aresetn=0, and after reset all outputs are 0.
